// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier family: FSM state encoding
// and sizing helpers for the iterative radix-4 Booth multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // One radix-4 digit per two multiplier bits, plus the top digit
    // that covers the two extension bits.
    function automatic int booth_digits(input int width);
        return width / 2 + 1;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width / 2 + 2);
    endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// Radix-4 Booth digit recoder and partial-product selector.
// Ports: code (b_ext[2i+1:2i-1]), a_ext (extended multiplicand),
//        pp (one's-complemented when neg), neg (carry-in to complete -x).
module booth_digit_sel #(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       code,
    input  logic [WIDTH+1:0] a_ext,
    output logic [WIDTH+2:0] pp,
    output logic             neg
);

    logic             one;
    logic             two;
    logic [WIDTH+2:0] mag;

    always_comb begin
        one = code[1] ^ code[0];
        two = (code == 3'b011) || (code == 3'b100);
        // 111 recodes to zero, so it must not invert.
        neg = code[2] & ~(code[1] & code[0]);
        mag = '0;
        if (one) begin
            mag = {a_ext[WIDTH+1], a_ext};
        end else if (two) begin
            mag = {a_ext, 1'b0};
        end
        pp = neg ? ~mag : mag;
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock.
// Ports: clk, rst_n (async low), in_valid/in_ready + a, b, signed_mode,
//        out_valid/out_ready + prod (2*WIDTH bits, registered).
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int N  = booth_digits(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    logic [WIDTH+1:0] a_ext;
    // Multiplier with the implicit b_ext[-1]=0 appended; bits [2:0]
    // are always the code of the current digit.
    logic [WIDTH+2:0] br;
    // Running sum (upper) and retired low bits of the shifting product.
    logic [WIDTH+2:0] hi;
    logic [WIDTH+1:0] lo;
    logic [CW-1:0]    cnt;

    logic [WIDTH+2:0] pp;
    logic             neg;
    logic [WIDTH+2:0] sum;
    logic [WIDTH+2:0] hi_nx;
    logic [WIDTH+1:0] lo_nx;
    logic [WIDTH+1:0] a_in;
    logic [WIDTH+1:0] b_in;

    booth_digit_sel #(
        .WIDTH(WIDTH)
    ) u_sel (
        .code  (br[2:0]),
        .a_ext (a_ext),
        .pp    (pp),
        .neg   (neg)
    );

    assign a_in = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign b_in = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

    // The running sum is bounded below 2^(WIDTH+2) in magnitude, so
    // WIDTH+3 bits never overflow; the arithmetic shift keeps it exact.
    assign sum   = hi + pp + {{(WIDTH+2){1'b0}}, neg};
    assign hi_nx = {{2{sum[WIDTH+2]}}, sum[WIDTH+2:2]};
    assign lo_nx = {sum[1:0], lo[WIDTH+1:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            prod      <= '0;
            a_ext     <= '0;
            br        <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_ext    <= a_in;
                        br       <= {b_in, 1'b0};
                        hi       <= '0;
                        lo       <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    hi  <= hi_nx;
                    lo  <= lo_nx;
                    br  <= {2'b00, br[WIDTH+2:2]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // After N shifts the low WIDTH+2 bits sit in lo.
                        prod      <= {hi_nx[WIDTH-3:0], lo_nx};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
